// File: rtl/i2s_transmit.sv
`default_nettype none
// ============================================================================
// i2s_transmit : I2S stereo serializer with a one-sample holding register
// Revision     : 1.0
// ============================================================================
module i2s_transmit #(
  parameter int DATA_SIZE = 24,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_SIZE-1:0] s_left,
  input  logic [DATA_SIZE-1:0] s_right,
  output logic                 i2s_sck,
  output logic                 i2s_ws,
  output logic                 i2s_sd,
  output logic                 frame_start,
  output logic                 underrun
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 sck_q, sck_d;
  logic                 ws_q, ws_d;
  logic                 sd_q, sd_d;
  logic [5:0]           bit_q, bit_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_SIZE-1:0] hold_l_q, hold_l_d;
  logic [DATA_SIZE-1:0] hold_r_q, hold_r_d;
  logic [DATA_SIZE-1:0] sh_l_q, sh_l_d;
  logic [DATA_SIZE-1:0] sh_r_q, sh_r_d;
  logic                 fs_q, fs_d;
  logic                 ur_q, ur_d;

  logic                 tick;
  logic                 fall;
  logic                 load;
  logic                 accept;
  logic [5:0]           bit_nx;

  assign tick   = (div_q == DIV_LAST);
  assign fall   = tick & sck_q;
  assign bit_nx = bit_q + 6'd1;
  assign load   = fall & (bit_nx == 6'd0);
  assign accept = s_valid & ~hold_full_q;

  always_comb begin
    div_d       = tick ? '0 : div_q + DIV_W'(1);
    sck_d       = tick ? ~sck_q : sck_q;
    bit_d       = bit_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    sh_l_d      = sh_l_q;
    sh_r_d      = sh_r_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    fs_d        = 1'b0;
    ur_d        = 1'b0;

    if (fall) begin
      bit_d = bit_nx;
      ws_d  = (bit_nx >= 6'd31) && (bit_nx <= 6'd62);
      // The MSB leaves on the same edge it is loaded, so slot 0 bypasses the shifter.
      if (load) begin
        fs_d = 1'b1;
        if (hold_full_q) begin
          sd_d        = hold_l_q[DATA_SIZE-1];
          sh_l_d      = hold_l_q << 1;
          sh_r_d      = hold_r_q;
          hold_full_d = 1'b0;
        end else begin
          sd_d   = 1'b0;
          sh_l_d = '0;
          sh_r_d = '0;
          ur_d   = 1'b1;
        end
      end else if (bit_nx < 6'd32) begin
        sd_d   = sh_l_q[DATA_SIZE-1];
        sh_l_d = sh_l_q << 1;
      end else begin
        sd_d   = sh_r_q[DATA_SIZE-1];
        sh_r_d = sh_r_q << 1;
      end
    end

    // accept never coincides with a full-holding load, since s_ready is low then
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = s_left;
      hold_r_d    = s_right;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q       <= '0;
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      bit_q       <= 6'd63;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      div_q       <= div_d;
      sck_q       <= sck_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      bit_q       <= bit_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
    end
  end

  assign s_ready     = ~hold_full_q;
  assign i2s_sck     = sck_q;
  assign i2s_ws      = ws_q;
  assign i2s_sd      = sd_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmit.sv
`default_nettype none
// ============================================================================
// tb_i2s_transmit : self-checking bench for i2s_transmit (DATA_SIZE=24, CLK_DIV=2)
// Revision        : 1.0
// ============================================================================
module tb_i2s_transmit;

  localparam int DS = 24;
  localparam int CD = 2;
  localparam int P  = 2 * CD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DS-1:0] s_left = '0;
  logic [DS-1:0] s_right = '0;
  logic          s_ready;
  logic          i2s_sck;
  logic          i2s_ws;
  logic          i2s_sd;
  logic          frame_start;
  logic          underrun;

  always #5 clk = ~clk;

  i2s_transmit #(.DATA_SIZE(DS), .CLK_DIV(CD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_left     (s_left),
    .s_right    (s_right),
    .i2s_sck    (i2s_sck),
    .i2s_ws     (i2s_ws),
    .i2s_sd     (i2s_sd),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0d, time %0t)", name, act, exp, t, $time);
  endtask

  // ---------------------------------------------------------------- reference model
  // Time-based view: t counts posedges since reset release; falling event k sits at
  // t = P*(k+1), and slot n = k mod 64 holds until the next event.
  int            t = 0;
  bit            m_full = 1'b0;
  logic [DS-1:0] m_hl = '0, m_hr = '0, m_cl = '0, m_cr = '0;
  bit            m_fs = 1'b0, m_ur = 1'b0, m_old;

  function automatic logic [5:0] expect_pins(input int tt, input logic [DS-1:0] l,
                                             input logic [DS-1:0] r, input bit full,
                                             input bit fs, input bit ur);
    int   n;
    logic sck, ws, sd;
    sck = ((tt / CD) % 2) == 1;
    ws  = 1'b0;
    sd  = 1'b0;
    if (tt >= P) begin
      n  = (tt / P - 1) % 64;
      ws = (n >= 31) && (n <= 62);
      if (n < DS) sd = l[DS-1-n];
      else if (n >= 32 && n < 32 + DS) sd = r[DS-1-(n-32)];
    end
    return {sck, ws, sd, fs, ur, ~full};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      m_fs = 1'b0;
      m_ur = 1'b0;
      if (!rst_n) begin
        t = 0; m_full = 1'b0; m_hl = '0; m_hr = '0; m_cl = '0; m_cr = '0;
      end else begin
        t++;
        m_old = m_full;
        if (t % P == 0 && ((t / P - 1) % 64) == 0) begin
          m_fs = 1'b1;
          if (m_full) begin
            m_cl = m_hl; m_cr = m_hr; m_full = 1'b0;
          end else begin
            m_cl = '0; m_cr = '0; m_ur = 1'b1;
          end
        end
        if (s_valid && !m_old) begin
          m_hl = s_left; m_hr = s_right; m_full = 1'b1;
        end
      end
      #1;
      check("pins{sck,ws,sd,fs,ur,ready}",
            {i2s_sck, i2s_ws, i2s_sd, frame_start, underrun, s_ready},
            expect_pins(t, m_cl, m_cr, m_full, m_fs, m_ur));
    end
  end

  // ---------------------------------------------------------------- helpers
  function automatic int slot_t(input int frame, input int n);
    return P * (64 * frame + n + 1);
  endfunction

  function automatic int next_load(input int tt);
    int m = 0;
    while (P * (64 * m + 1) <= tt + 1) m++;
    return P * (64 * m + 1);
  endfunction

  task automatic wait_t(input int target);
    int guard = 0;
    while (t < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (t != target) check("wait_t_reached", t, target);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_pins", {i2s_sck, i2s_ws, i2s_sd, frame_start, underrun, s_ready}, 6'b000001);
    repeat (cycles - 1) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Garbage is driven while s_ready is low; only the real sample is present at accept.
  task automatic offer(input logic [DS-1:0] l, input logic [DS-1:0] r, input bit drop);
    int g = 0;
    s_valid = 1'b1;
    while (!s_ready && g < 3000) begin
      s_left  = DS'($urandom);
      s_right = DS'($urandom);
      @(negedge clk);
      g++;
    end
    if (!s_ready) check("offer_ready_timeout", 32'd0, 32'd1);
    s_left  = l;
    s_right = r;
    @(negedge clk);
    check("ready_drop_after_accept", s_ready, 1'b0);
    if (drop) s_valid = 1'b0;
  endtask

  typedef struct {
    int   frame;
    int   n;
    logic sd;
    logic ws;
  } slot_vec_t;

  slot_vec_t vecs[$];

  int            ur_cnt, fs_cnt, ws_cnt, sd_cnt, tl, tries;
  bit            second_sent, acc_next;
  logic [DS-1:0] samp_l[3];
  logic [DS-1:0] samp_r[3];
  logic [DS-1:0] x1;

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    // frame 0 carries L=A5A5A5 R=5A5A5A, frame 1 carries L=800000 R=000001
    vecs.push_back('{0,  0, 1'b1, 1'b0});
    vecs.push_back('{0,  1, 1'b0, 1'b0});
    vecs.push_back('{0,  2, 1'b1, 1'b0});
    vecs.push_back('{0,  3, 1'b0, 1'b0});
    vecs.push_back('{0,  4, 1'b0, 1'b0});
    vecs.push_back('{0,  5, 1'b1, 1'b0});
    vecs.push_back('{0,  7, 1'b1, 1'b0});
    vecs.push_back('{0, 23, 1'b1, 1'b0});
    vecs.push_back('{0, 24, 1'b0, 1'b0});
    vecs.push_back('{0, 30, 1'b0, 1'b0});
    vecs.push_back('{0, 31, 1'b0, 1'b1});
    vecs.push_back('{0, 32, 1'b0, 1'b1});
    vecs.push_back('{0, 33, 1'b1, 1'b1});
    vecs.push_back('{0, 54, 1'b1, 1'b1});
    vecs.push_back('{0, 55, 1'b0, 1'b1});
    vecs.push_back('{0, 56, 1'b0, 1'b1});
    vecs.push_back('{0, 62, 1'b0, 1'b1});
    vecs.push_back('{0, 63, 1'b0, 1'b0});
    vecs.push_back('{1,  0, 1'b1, 1'b0});
    vecs.push_back('{1,  1, 1'b0, 1'b0});
    vecs.push_back('{1, 22, 1'b0, 1'b0});
    vecs.push_back('{1, 23, 1'b0, 1'b0});
    vecs.push_back('{1, 32, 1'b0, 1'b1});
    vecs.push_back('{1, 54, 1'b0, 1'b1});
    vecs.push_back('{1, 55, 1'b1, 1'b1});
    vecs.push_back('{1, 56, 1'b0, 1'b1});

    // idle run: two frames with no input
    do_reset(3);
    ur_cnt = 0; fs_cnt = 0; ws_cnt = 0; sd_cnt = 0;
    for (int c = 0; c < 512; c++) begin
      @(negedge clk);
      ur_cnt += int'(underrun);
      fs_cnt += int'(frame_start);
      sd_cnt += int'(i2s_sd);
      if (t >= P && t < P + 256) ws_cnt += int'(i2s_ws);
    end
    check("idle_underrun_pulses", ur_cnt, 2);
    check("idle_frame_starts", fs_cnt, 2);
    check("idle_ws_high_clks", ws_cnt, 128);
    check("idle_sd_ones", sd_cnt, 0);

    // directed slot table
    do_reset(2);
    offer(24'hA5A5A5, 24'h5A5A5A, 1'b1);
    wait_t(P);
    check("first_load_no_underrun", underrun, 1'b0);
    check("first_load_frame_start", frame_start, 1'b1);
    second_sent = 1'b0;
    foreach (vecs[i]) begin
      if (vecs[i].frame == 1 && !second_sent) begin
        wait_t(slot_t(0, 63));
        offer(24'h800000, 24'h000001, 1'b1);
        second_sent = 1'b1;
      end
      wait_t(slot_t(vecs[i].frame, vecs[i].n));
      check($sformatf("f%0d_n%0d_sd", vecs[i].frame, vecs[i].n), i2s_sd, vecs[i].sd);
      check($sformatf("f%0d_n%0d_ws", vecs[i].frame, vecs[i].n), i2s_ws, vecs[i].ws);
    end

    // back-to-back offers with s_valid held high
    samp_l[0] = 24'h123456; samp_r[0] = 24'hFEDCBA;
    samp_l[1] = 24'h800001; samp_r[1] = 24'h7FFFFE;
    samp_l[2] = 24'h0F0F0F; samp_r[2] = 24'hF0F0F0;
    for (int i = 0; i < 3; i++) offer(samp_l[i], samp_r[i], i == 2);

    // offer landing exactly on an empty-holding load cycle
    tries = 0;
    do begin
      tl = next_load(t);
      wait_t(tl - 1);
      tries++;
    end while (m_full && tries < 6);
    x1 = 24'hC0FFEE;
    s_valid = 1'b1; s_left = x1; s_right = 24'h00BEEF;
    @(negedge clk);
    s_valid = 1'b0;
    check("same_cycle_underrun", underrun, 1'b1);
    check("same_cycle_held", s_ready, 1'b0);
    wait_t(tl + 64 * P);
    check("same_cycle_next_frame_msb", i2s_sd, x1[DS-1]);
    check("same_cycle_next_no_underrun", underrun, 1'b0);

    // reset mid-frame with a sample held
    tl = next_load(t);
    wait_t(tl + 5 * P);
    offer(24'hABCDEF, 24'h135790, 1'b1);
    wait_t(tl + 40 * P);
    check("held_before_reset", s_ready, 1'b0);
    check("ws_before_reset", i2s_ws, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_sck", i2s_sck, 1'b0);
    check("rst_ws", i2s_ws, 1'b0);
    check("rst_sd", i2s_sd, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ready", s_ready, 1'b1);
    rst_n = 1'b1;
    wait_t(P - 1);
    check("post_rst_no_early_load", frame_start, 1'b0);
    wait_t(P);
    check("post_rst_underrun", underrun, 1'b1);
    check("post_rst_frame_start", frame_start, 1'b1);

    // randomized traffic with occasional resets, checked by the model
    acc_next = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      if (s_valid && acc_next) begin
        s_valid  = 1'b0;
        acc_next = 1'b0;
      end
      if (!s_valid && $urandom_range(0, 59) == 0) begin
        s_valid = 1'b1;
        s_left  = DS'($urandom);
        s_right = DS'($urandom);
      end else if (s_valid && !s_ready) begin
        s_left  = DS'($urandom);
        s_right = DS'($urandom);
      end
      acc_next = s_valid && s_ready && rst_n;
    end
    s_valid = 1'b0;
    rst_n   = 1'b1;
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_transmit.md
I2S_TRANSMIT -- requirements
Module: i2s_transmit

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default 24, meaning sample width per channel; legal values 1..32.
REQ-002 The module SHALL have parameter CLK_DIV, default 2, meaning clk cycles per sck half-period; legal values >= 1.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 s_valid  input  1  stereo sample offered.
REQ-006 s_ready  output  1  holding register empty; sample accepted when s_valid && s_ready at posedge.
REQ-007 s_left  input  DATA_SIZE  left sample, two's complement.
REQ-008 s_right  input  DATA_SIZE  right sample, two's complement.
REQ-009 i2s_sck  output  1  bit clock, generated.
REQ-010 i2s_ws  output  1  word select; 0 = left, 1 = right.
REQ-011 i2s_sd  output  1  serial data, MSB first.
REQ-012 frame_start  output  1  one-clk pulse at each frame load.
REQ-013 underrun  output  1  one-clk pulse when a frame loads with the holding register empty.

Function
REQ-014 div_cnt SHALL count 0..CLK_DIV-1 and wrap; i2s_sck SHALL toggle on the cycle div_cnt == CLK_DIV-1.
REQ-015 A falling event SHALL be the cycle i2s_sck toggles 1->0; ws, sd, bit_cnt and the frame load SHALL update only on falling events.
REQ-016 bit_cnt (6 bits) SHALL advance by 1 mod 64 on each falling event; the frame is 64 sck periods, 32 slots per channel.
REQ-017 On the falling event where bit_cnt becomes n, i2s_ws SHALL be 1 for n in 31..62 and 0 otherwise, so WS leads each channel MSB by one sck.
REQ-018 i2s_sd SHALL be left bit DATA_SIZE-1-n for n in 0..DATA_SIZE-1, right bit DATA_SIZE-1-(n-32) for n in 32..31+DATA_SIZE, and 0 in all other slots.
REQ-019 The frame load SHALL occur on the falling event where bit_cnt becomes 0: if holding is full, copy it to the left/right shift registers and clear holding; otherwise load zeros and pulse underrun.
REQ-020 The MSB driven at n = 0 SHALL be the value loaded on that same event; no extra frame of latency.
REQ-021 frame_start SHALL pulse on every frame load, independent of underrun.
REQ-022 s_ready SHALL equal the inverse of the registered holding-full flag, with no combinational path from s_valid.
REQ-023 Accept and load in the same cycle: a load sees the holding state before the accept, so a sample accepted on a load cycle with holding empty is stored for the next frame and underrun still pulses.
REQ-024 s_left/s_right SHALL be captured only on accept; changes on the inputs while s_ready = 0 SHALL have no effect.
REQ-025 Sample-to-pin latency SHALL be at most 1 frame (64*2*CLK_DIV clk) plus 1 clk.

Reset
REQ-026 While rst_n = 0, i2s_sck, i2s_ws, i2s_sd, frame_start and underrun SHALL be 0, s_ready SHALL be 1, div_cnt SHALL be 0, bit_cnt SHALL be 63, and the holding and shift registers SHALL be cleared.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately and discard any held sample.
REQ-028 After release, the first falling event SHALL occur 2*CLK_DIV clk later and perform a frame load.

Verification (DATA_SIZE = 24, CLK_DIV = 2, frame = 256 clk)
REQ-029 Reset release, no input -> sck period 4 clk; underrun and frame_start pulse every 256 clk; sd stays 0; ws low 128 clk and high 128 clk, rising on the falling event n = 31.
REQ-030 Offer L = 0xA5A5A5, R = 0x5A5A5A before the first load -> s_ready drops; at n = 0..23 sd = 1,0,1,0,0,1,0,1... (0xA5A5A5 MSB first); n = 24..31 sd = 0; n = 32..55 sd carries 0x5A5A5A; no underrun.
REQ-031 Hold s_valid = 1 with 3 distinct samples -> exactly one accept per frame; transmitted order matches offer order; s_ready rises the cycle after each load.
REQ-032 Present a sample exactly on a load cycle with holding empty -> underrun pulses; the sample is transmitted in the following frame.
REQ-033 Send L = 0x800000, R = 0x000001 -> left MSB slot = 1 with the other 23 bits 0; right bit at n = 55 = 1.
REQ-034 Assert rst_n = 0 at n = 40 with a sample held -> all outputs match REQ-026 on the next posedge; after release, the first frame underruns.
